vx_csr_io_initiator: RTL



---
 rtl/vx_csr_io_initiator_pkg.sv | 6 +
 rtl/vx_csr_io_initiator_if.sv | 36 +++
 rtl/vx_csr_io_initiator.sv | 111 +++++++++++
 3 files changed

// File: rtl/vx_csr_io_initiator_pkg.sv
// vx_csr_io_initiator_pkg: shared constants and state encoding for the host-side CSR I/O initiator.
package vx_csr_io_initiator_pkg;
   localparam int          CSR_ADDR_BITS = 12;
   localparam logic [31:0] CSR_ERR_DATA  = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} csr_state_e;
endpackage

// File: rtl/vx_csr_io_initiator_if.sv
// vx_csr_io_initiator_if: host command/response path plus the per-core csr_io request/response bundle.
interface vx_csr_io_initiator_if #(parameter int NUM_CORES = 4);
   import vx_csr_io_initiator_pkg::*;
   localparam int CORE_BITS = $clog2(NUM_CORES) + 1;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_rw;
   logic [CORE_BITS-1:0]     cmd_core;
   logic [CSR_ADDR_BITS-1:0] cmd_addr;
   logic [31:0]              cmd_data;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [31:0]              rsp_data;
   logic                     rsp_err;
   logic [NUM_CORES-1:0]     csr_io_req_valid;
   logic                     csr_io_req_rw;
   logic [CSR_ADDR_BITS-1:0] csr_io_req_addr;
   logic [31:0]              csr_io_req_data;
   logic [NUM_CORES-1:0]     csr_io_req_ready;
   logic [NUM_CORES-1:0]     csr_io_rsp_valid;
   logic [NUM_CORES*32-1:0]  csr_io_rsp_data;
   logic [NUM_CORES-1:0]     csr_io_rsp_ready;
   logic                     busy;
   modport master (
      input  cmd_valid, cmd_rw, cmd_core, cmd_addr, cmd_data, rsp_ready,
             csr_io_req_ready, csr_io_rsp_valid, csr_io_rsp_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, csr_io_req_valid, csr_io_req_rw,
             csr_io_req_addr, csr_io_req_data, csr_io_rsp_ready, busy
   );
   modport slave (
      output cmd_valid, cmd_rw, cmd_core, cmd_addr, cmd_data, rsp_ready,
             csr_io_req_ready, csr_io_rsp_valid, csr_io_rsp_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, csr_io_req_valid, csr_io_req_rw,
             csr_io_req_addr, csr_io_req_data, csr_io_rsp_ready, busy
   );
endinterface

// File: rtl/vx_csr_io_initiator.sv
// vx_csr_io_initiator: steers one host CSR command at a time to a core and returns its response,
// or an error on bad core index / timeout.
module vx_csr_io_initiator
   import vx_csr_io_initiator_pkg::*;
#(
   parameter int NUM_CORES      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                   clk,
   input logic                   reset,
   vx_csr_io_initiator_if.master bus
);
   localparam int                    CORE_BITS  = $clog2(NUM_CORES) + 1;
   localparam int                    TIMER_BITS = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [CORE_BITS-1:0]  CORE_LIMIT = CORE_BITS'(NUM_CORES);
   csr_state_e               state;
   logic [TIMER_BITS-1:0]    timer;
   logic [NUM_CORES-1:0]     sel, cmd_sel, req_valid, rsp_ready;
   logic                     rw, cmd_ready, rsp_valid, rsp_err, busy;
   logic [CSR_ADDR_BITS-1:0] addr;
   logic [31:0]              data, rsp_data, core_data;
   logic                     req_hs, rsp_hs, expired;
   // an out-of-range index shifts the one-hot bit off the top, so a bad command selects no core
   assign cmd_sel = NUM_CORES'(1) << bus.cmd_core;
   assign req_hs  = |(req_valid & bus.csr_io_req_ready);
   assign rsp_hs  = (state == RSP) && |(sel & bus.csr_io_rsp_valid);
   assign expired = timer == TIMER_LAST;
   always_comb begin
      core_data = '0;
      for (int i = 0; i < NUM_CORES; i++)
         core_data = core_data | (sel[i] ? bus.csr_io_rsp_data[32*i +: 32] : 32'h0);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         timer     <= '0;
         sel       <= '0;
         rw        <= 1'b0;
         addr      <= '0;
         data      <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         req_valid <= '0;
         rsp_ready <= '1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid) begin
               rw        <= bus.cmd_rw;
               addr      <= bus.cmd_addr;
               data      <= bus.cmd_data;
               sel       <= cmd_sel;
               timer     <= '0;
               cmd_ready <= 1'b0;
               busy      <= 1'b1;
               if (bus.cmd_core >= CORE_LIMIT) begin
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= CSR_ERR_DATA;
               end else begin
                  state     <= REQ;
                  req_valid <= cmd_sel;
               end
            end
            REQ, RSP: begin
               timer <= timer + TIMER_BITS'(!expired);
               // a handshake on the terminal cycle takes priority over the timeout
               if (req_hs) begin
                  state     <= RSP;
                  req_valid <= '0;
                  rsp_ready <= ~sel;
               end else if (rsp_hs) begin
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= core_data;
                  rsp_ready <= '1;
               end else if (expired) begin
                  state     <= DONE;
                  req_valid <= '0;
                  rsp_ready <= '1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= CSR_ERR_DATA;
               end
            end
            DONE: if (bus.rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.cmd_ready        = cmd_ready;
   assign bus.rsp_valid        = rsp_valid;
   assign bus.rsp_data         = rsp_data;
   assign bus.rsp_err          = rsp_err;
   assign bus.csr_io_req_valid = req_valid;
   assign bus.csr_io_req_rw    = rw;
   assign bus.csr_io_req_addr  = addr;
   assign bus.csr_io_req_data  = data;
   assign bus.csr_io_rsp_ready = rsp_ready;
   assign bus.busy             = busy;
endmodule
